// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter sharing one UART transmitter among packet requesters
module uart_tx_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter int START_TO = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_din,
  input  logic                 tx_busy,
  input  logic                 tx_done,
  output logic                 grant_valid,
  output logic [ID_W-1:0]      grant_id,
  output logic                 err_timeout
);
  localparam int CW = $clog2(START_TO + 1);
  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state_q, state_d;
  logic lock_q, lock_d, last_q, last_d, err_q, err_d, hit, fin;
  logic [ID_W-1:0] ptr_q, ptr_d, owner_q, owner_d, win, nxt, off;
  logic [7:0] din_q, din_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NUM_REQ-1:0] elig, rot;
  // a held packet lock narrows arbitration to the owner alone
  assign elig = lock_q ? req_valid & (NUM_REQ'(1) << owner_q) : req_valid;
  assign rot = NUM_REQ'({elig, elig} >> ptr_q);
  assign nxt = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + 1'b1;
  assign win = ID_W'((int'(ptr_q) + int'(off)) % NUM_REQ);
  assign fin = (state_q == WAIT_BUSY || state_q == WAIT_DONE) && tx_done;
  assign req_ready = (rst && state_q == IDLE && hit) ? NUM_REQ'(1) << win : '0;
  assign tx_start = state_q == START;
  assign tx_din = din_q;
  assign grant_valid = state_q != IDLE || lock_q;
  assign grant_id = owner_q;
  assign err_timeout = err_q;
  always_comb begin
    hit = 1'b0;
    off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        hit = 1'b1;
        off = ID_W'(k);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    lock_d = lock_q;
    ptr_d = ptr_q;
    owner_d = owner_q;
    last_d = last_q;
    din_d = din_q;
    cnt_d = cnt_q;
    err_d = 1'b0;
    if (fin) begin
      lock_d = !last_q;
      ptr_d = last_q ? nxt : ptr_q;
      state_d = IDLE;
    end else if (state_q == IDLE && hit) begin
      owner_d = win;
      din_d = req_data[{win, 3'b000} +: 8];
      last_d = req_last[win];
      state_d = START;
    end else if (state_q == START) begin
      cnt_d = '0;
      state_d = WAIT_BUSY;
    end else if (state_q == WAIT_BUSY && tx_busy) begin
      state_d = WAIT_DONE;
    end else if (state_q == WAIT_BUSY && cnt_q == CW'(START_TO - 1)) begin
      err_d = 1'b1;
      lock_d = 1'b0;
      ptr_d = nxt;
      state_d = IDLE;
    end else if (state_q == WAIT_BUSY) begin
      cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      lock_q <= 1'b0;
      last_q <= 1'b0;
      err_q <= 1'b0;
      ptr_q <= '0;
      owner_q <= '0;
      din_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      lock_q <= lock_d;
      last_q <= last_d;
      err_q <= err_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      din_q <= din_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed stimulus checked against a timestamp-based transfer model
module tb_uart_tx_scheduler;
  localparam int NQ = 4, IW = 2, STO = 16;
  logic clk = 1'b0, rst = 1'b1, tx_busy = 1'b0, tx_done = 1'b0;
  logic [NQ-1:0] req_valid = '0, req_last = '0, req_ready;
  logic [8*NQ-1:0] req_data = '0;
  logic tx_start, grant_valid, err_timeout;
  logic [7:0] tx_din;
  logic [IW-1:0] grant_id;
  int total = 0, bad = 0, cyc = 0, r0_cnt = 0;
  int order [5] = '{1, 2, 3, 0, 1};
  int m_acc = 0, m_own = 0, m_ptr = 0, w = 0, ii = 0;
  bit m_fly, m_busy, m_lock, m_last, m_err;
  logic [7:0] m_din;
  logic [NQ-1:0] e_ready;

  uart_tx_scheduler #(.NUM_REQ(NQ), .ID_W(IW), .START_TO(STO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .tx_start(tx_start), .tx_din(tx_din), .tx_busy(tx_busy),
    .tx_done(tx_done), .grant_valid(grant_valid), .grant_id(grant_id), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_start(output int id, output int at);
    int n = 0;
    while (tx_start !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("start_seen", 32'(tx_start), 1);
    id = int'(grant_id);
    at = cyc;
  endtask

  // transmitter: busy from the cycle after the start pulse, done on its len-th busy cycle
  task automatic xmit(input int len);
    @(posedge clk); #1;
    tx_busy = 1'b1;
    tx_done = 1'b0;
    repeat (len - 1) begin
      @(posedge clk); #1;
    end
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_busy = 1'b0;
    tx_done = 1'b0;
  endtask

  // model: a transfer accepted at cycle a pulses start at a+1 and listens to busy/done from a+2
  initial forever begin
    @(negedge clk);
    cyc++;
    e_ready = '0;
    w = -1;
    if (!rst) begin
      m_fly = 0; m_busy = 0; m_lock = 0; m_last = 0; m_err = 0;
      m_ptr = 0; m_own = 0; m_din = '0;
    end else if (!m_fly) begin
      for (int k = 0; k < NQ; k++) begin
        ii = (m_ptr + k) % NQ;
        if (w < 0 && req_valid[IW'(ii)] && (!m_lock || ii == m_own)) w = ii;
      end
    end
    if (w >= 0) e_ready[IW'(w)] = 1'b1;
    if (req_ready[0]) r0_cnt++;
    chk("req_ready", 32'(req_ready), 32'(e_ready));
    chk("tx_start", 32'(tx_start), 32'(m_fly && cyc == m_acc + 1));
    chk("tx_din", 32'(tx_din), 32'(m_din));
    chk("grant_valid", 32'(grant_valid), 32'(m_fly || m_lock));
    chk("grant_id", 32'(grant_id), 32'(m_own));
    chk("err_timeout", 32'(err_timeout), 32'(m_err));
    m_err = 0;
    if (w >= 0) begin
      m_fly = 1; m_busy = 0; m_acc = cyc; m_own = w;
      m_din = req_data[{IW'(w), 3'b000} +: 8];
      m_last = req_last[IW'(w)];
    end else if (m_fly && cyc >= m_acc + 2) begin
      if (tx_done) begin
        m_fly = 0;
        m_lock = !m_last;
        if (m_last) m_ptr = (m_own + 1) % NQ;
      end else if (!m_busy && tx_busy) begin
        m_busy = 1;
      end else if (!m_busy && cyc == m_acc + 1 + STO) begin
        m_fly = 0; m_lock = 0; m_err = 1;
        m_ptr = (m_own + 1) % NQ;
      end
    end
  end

  initial begin
    int id, t0, t1, n, r0;
    t0 = 0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("reset_outs", 32'({req_ready, tx_start, tx_din, grant_valid, grant_id, err_timeout}), 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 req_valid = 4'b0001; req_last = 4'b0001; req_data[7:0] = 8'hA5;
    #1 chk("t1_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = '0;
    req_data[7:0] = 8'h3C;
    chk("t1_start", 32'(tx_start), 1);
    chk("t1_din", 32'(tx_din), 32'hA5);
    xmit(10);
    chk("t1_release", 32'(grant_valid), 0);
    req_valid = '1; req_last = '1; req_data = 32'h44332211;
    for (int j = 0; j < 5; j++) begin
      wait_start(id, t1);
      chk("t2_order", id, order[j]);
      if (j > 0) chk("t2_spacing", t1 - t0, 7);
      t0 = t1;
      xmit(5);
    end
    req_valid = 4'b0101; req_last = 4'b0001; req_data = 32'h00B1000F;
    r0 = r0_cnt;
    for (int b = 0; b < 3; b++) begin
      wait_start(id, t1);
      chk("t3_packet", id, 2);
      chk("t3_din", 32'(tx_din), 32'hB1 + b);
      req_data[23:16] = 8'hB2 + 8'(b);
      if (b == 1) req_last[2] = 1'b1;
      if (b == 2) req_valid[2] = 1'b0;
      xmit(3);
    end
    chk("t3_r0_quiet", r0_cnt - r0, 0);
    wait_start(id, t1);
    chk("t3_after", id, 0);
    req_valid = '1; req_last = 4'b1101; req_data[15:8] = 8'hC1;
    xmit(3);
    wait_start(id, t1);
    chk("t4_owner", id, 1);
    req_valid[1] = 1'b0;
    xmit(3);
    for (int g = 0; g < 20; g++) begin
      chk("t4_gap_start", 32'(tx_start), 0);
      chk("t4_gap_grant", 32'(grant_valid), 1);
      chk("t4_gap_ready", 32'(req_ready), 0);
      @(posedge clk); #1;
    end
    req_valid[1] = 1'b1; req_last[1] = 1'b1; req_data[15:8] = 8'hC2;
    wait_start(id, t1);
    chk("t4_resume", id, 1);
    chk("t4_din", 32'(tx_din), 32'hC2);
    req_valid[1] = 1'b0; req_last[2] = 1'b0; req_data[23:16] = 8'hD1;
    xmit(3);
    wait_start(id, t1);
    chk("t5_first", id, 2);
    req_data[23:16] = 8'hD2;
    xmit(3);
    wait_start(id, t1);
    chk("t5_locked", id, 2);
    n = 0;
    while (err_timeout !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t5_timeout_cycles", n - 1, STO);
    chk("t5_lock_cleared", 32'(grant_valid), 0);
    req_valid = '1;
    wait_start(id, t1);
    chk("t5_next", id, 3);
    @(posedge clk); #1 tx_busy = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1 chk("t6_reset_outs", 32'({req_ready, tx_start, tx_din, grant_valid, grant_id, err_timeout}), 0);
    tx_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1; tx_done = 1'b1;
    #1 chk("t6_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    chk("t6_start", 32'(tx_start), 1);
    chk("t6_owner", 32'(grant_id), 0);
    xmit(4);
    req_valid = '0;
    repeat (5) @(posedge clk);
    #1 chk("t6_idle", 32'(grant_valid), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
